line_raster_ctrl: RTL
=====================

LINE_RASTER_CTRL -- requirements
Module: line_raster_ctrl

Interface
REQ-001 Parameter X_RES, default 640, visible width in pixels; pixels with x >= X_RES are off-screen.
REQ-002 Parameter Y_RES, default 480, visible height in pixels; pixels with y >= Y_RES are off-screen.
REQ-003 Parameter CMD_DEPTH, default 2, number of line-command buffer entries.
REQ-004 Port clk  input  1  sole clock; all state on rising edge.
REQ-005 Port rst_n  input  1  one clock; reset is asynchronous and active-low.
REQ-006 Port cmd_valid  input  1  line command offered.
REQ-007 Port cmd_ready  output  1  command buffer not full.
REQ-008 Port cmd_x1, cmd_y1, cmd_x2, cmd_y2  input  10 each  unsigned endpoints.
REQ-009 Port cmd_color  input  8  pixel color for the whole line.
REQ-010 Port abort  input  1  synchronous flush of active line and buffer.
REQ-011 Port px_valid  output  1  pixel write offered.
REQ-012 Port px_ready  input  1  framebuffer accepts pixel.
REQ-013 Port px_x, px_y  output  10 each  pixel coordinate; px_color  output  8.
REQ-014 Port busy  output  1  line active or buffer non-empty.
REQ-015 Port line_done  output  1  one-cycle pulse when a line's final step completes.

Function
REQ-016 Command accepted on cycle where cmd_valid && cmd_ready; pushed into a FIFO of CMD_DEPTH entries; cmd_ready = !full, independent of cmd_valid.
REQ-017 FSM states IDLE, SETUP, DRAW; IDLE->SETUP when FIFO non-empty; SETUP->DRAW after exactly one cycle; DRAW->SETUP on final step if FIFO non-empty, else DRAW->IDLE.
REQ-018 SETUP pops the FIFO head and loads x=x1, y=y1, dx=|x2-x1|, dy=-|y2-y1|, sx=+1/-1 (x2>=x1 gives +1), sy likewise, err=dx+dy; err 12-bit signed, e2=2*err 13-bit signed.
REQ-019 Latency: command accepted into empty FIFO while IDLE at cycle N -> SETUP at N+1 -> px_valid at N+2 (on-screen first pixel).
REQ-020 In DRAW, a step occurs when the current pixel is on-screen and px_valid && px_ready, or immediately (one cycle, px_valid low) when the current pixel is off-screen.
REQ-021 Step: if (x,y)==(x2,y2) the line ends; else using pre-step err: e2>=dy adds dy and x+=sx; e2<=dx adds dx and y+=sy; both may apply in one step, combined into one err update.
REQ-022 px_x/px_y/px_color shall be stable while px_valid && !px_ready; px_valid never deasserts without a handshake except by abort or reset.
REQ-023 Degenerate line (x1==x2, y1==y2) emits exactly one pixel (if on-screen) then ends.
REQ-024 line_done pulses in the cycle after the final step; lines are drawn strictly in acceptance order; no pixel of line k+1 precedes line_done of line k.
REQ-025 abort: next cycle FSM=IDLE, FIFO empty, px_valid=0, no line_done; a command presented with abort in the same cycle is dropped (cmd_ready ignored).
REQ-026 Simultaneous push and pop on a full FIFO: push accepted only if cmd_ready was high that cycle (no bypass).
REQ-027 busy = (state != IDLE) || FIFO non-empty.

Reset
REQ-028 On rst_n low, asynchronously: state=IDLE, FIFO empty, px_valid=0, px_x=px_y=0, px_color=0, line_done=0, busy=0, cmd_ready=1 after release.
REQ-029 Reset mid-line discards all state; the first cycle after release behaves as an idle power-up.

Structure
REQ-030 Shared package holds coordinate width (10), color width (8), default X_RES/Y_RES, and FSM state encodings.
REQ-031 One sub-module: line_cmd_fifo (parameterised depth/width synchronous FIFO with flush); Bresenham stepper stays in the top.

Verification
REQ-032 (0,0)->(3,0), color 0x1F, px_ready=1 -> pixels (0,0),(1,0),(2,0),(3,0), first at N+2, then line_done.
REQ-033 (0,0)->(1,3) -> exactly (0,0),(0,1),(1,2),(1,3); reversed (5,5)->(2,2) -> (5,5),(4,4),(3,3),(2,2).
REQ-034 (638,0)->(641,0) -> only (638,0),(639,0) emitted; line_done after 4 steps (2 handshakes + 2 silent).
REQ-035 Random px_ready stalls on (10,10)->(17,13) -> outputs held stable during stall; pixel sequence identical to no-stall run.
REQ-036 Three back-to-back commands, CMD_DEPTH=2, px_ready=0 -> cmd_ready drops after buffer fills; lines complete in order once px_ready=1.
REQ-037 abort mid-line with one queued command -> px_valid=0 and busy=0 next cycle, no line_done; reset mid-line gives identical result.

Source files
------------

// File: rtl/line_raster_pkg.sv
// Shared types and constants for the line rasteriser: coordinate/colour widths,
// default screen size, FSM encoding and the queued line-command record.
package line_raster_pkg;

  localparam int COORD_W   = 10;
  localparam int COLOR_W   = 8;
  localparam int ERR_W     = 12;
  localparam int DEF_X_RES = 640;
  localparam int DEF_Y_RES = 480;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x1;
    logic [COORD_W-1:0] y1;
    logic [COORD_W-1:0] x2;
    logic [COORD_W-1:0] y2;
    logic [COLOR_W-1:0] color;
  } line_cmd_t;

  localparam int CMD_W = $bits(line_cmd_t);

  function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/line_cmd_fifo.sv
// Small synchronous FIFO holding pending line commands; flush empties it in one
// cycle. Push into a full FIFO is refused even if a pop happens the same cycle.
module line_cmd_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign dout   = r_mem[r_rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is left unreset; occupancy is tracked by the pointers and
  // count, so stale entries are never observed.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/line_raster_ctrl.sv
// Bresenham line rasteriser: buffers line commands, walks each line one pixel
// per step and offers on-screen pixels over a valid/ready write port.
module line_raster_ctrl
  import line_raster_pkg::*;
#(
  parameter int X_RES     = DEF_X_RES,
  parameter int Y_RES     = DEF_Y_RES,
  parameter int CMD_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COORD_W-1:0] cmd_x2,
  input  logic [COORD_W-1:0] cmd_y2,
  input  logic [COLOR_W-1:0] cmd_color,
  input  logic               abort,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [COORD_W-1:0] px_x,
  output logic [COORD_W-1:0] px_y,
  output logic [COLOR_W-1:0] px_color,
  output logic               busy,
  output logic               line_done
);

  state_t r_state;
  state_t w_state_next;

  line_cmd_t w_cmd_in;
  line_cmd_t w_cmd_head;
  logic      w_full;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;

  logic [COORD_W-1:0]      r_x;
  logic [COORD_W-1:0]      r_y;
  logic [COORD_W-1:0]      r_x2;
  logic [COORD_W-1:0]      r_y2;
  logic [COLOR_W-1:0]      r_color;
  logic signed [ERR_W-1:0] r_dx;
  logic signed [ERR_W-1:0] r_dy;
  logic signed [ERR_W-1:0] r_err;
  logic                    r_sx_neg;
  logic                    r_sy_neg;
  logic                    r_line_done;

  logic signed [ERR_W-1:0] w_adx;
  logic signed [ERR_W-1:0] w_ady;
  logic signed [ERR_W:0]   w_e2;
  logic signed [ERR_W:0]   w_dx_ext;
  logic signed [ERR_W:0]   w_dy_ext;
  logic signed [ERR_W-1:0] w_err_next;
  logic                    w_step_x;
  logic                    w_step_y;
  logic                    w_on_screen;
  logic                    w_last;
  logic                    w_step;
  logic                    w_final;

  assign w_cmd_in = '{x1: cmd_x1, y1: cmd_y1, x2: cmd_x2, y2: cmd_y2, color: cmd_color};
  // A command offered alongside abort is dropped, whatever cmd_ready says.
  assign w_push   = cmd_valid && !w_full && !abort;

  line_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (abort),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_cmd_in),
    .dout  (w_cmd_head),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_adx = ERR_W'(abs_diff(w_cmd_head.x2, w_cmd_head.x1));
  assign w_ady = ERR_W'(abs_diff(w_cmd_head.y2, w_cmd_head.y1));

  assign w_on_screen = (32'(r_x) < X_RES) && (32'(r_y) < Y_RES);
  assign w_last      = (r_x == r_x2) && (r_y == r_y2);
  // Off-screen pixels are skipped silently in one cycle each.
  assign w_step      = (r_state == ST_DRAW) && (w_on_screen ? px_ready : 1'b1);
  assign w_final     = w_step && w_last;

  assign w_e2       = {r_err, 1'b0};
  assign w_dx_ext   = {r_dx[ERR_W-1], r_dx};
  assign w_dy_ext   = {r_dy[ERR_W-1], r_dy};
  assign w_step_x   = (w_e2 >= w_dy_ext);
  assign w_step_y   = (w_e2 <= w_dx_ext);
  assign w_err_next = r_err + (w_step_x ? r_dy : '0) + (w_step_y ? r_dx : '0);

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    if (abort) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (!w_empty || w_push) w_state_next = ST_SETUP;
        ST_SETUP: begin
          w_pop        = 1'b1;
          w_state_next = ST_DRAW;
        end
        ST_DRAW:  if (w_final) w_state_next = w_empty ? ST_IDLE : ST_SETUP;
        default:  w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x         <= '0;
      r_y         <= '0;
      r_x2        <= '0;
      r_y2        <= '0;
      r_color     <= '0;
      r_dx        <= '0;
      r_dy        <= '0;
      r_err       <= '0;
      r_sx_neg    <= 1'b0;
      r_sy_neg    <= 1'b0;
      r_line_done <= 1'b0;
    end else begin
      r_line_done <= w_final && !abort;
      if (r_state == ST_SETUP && !abort) begin
        r_x      <= w_cmd_head.x1;
        r_y      <= w_cmd_head.y1;
        r_x2     <= w_cmd_head.x2;
        r_y2     <= w_cmd_head.y2;
        r_color  <= w_cmd_head.color;
        r_sx_neg <= (w_cmd_head.x2 < w_cmd_head.x1);
        r_sy_neg <= (w_cmd_head.y2 < w_cmd_head.y1);
        r_dx     <= w_adx;
        r_dy     <= -w_ady;
        r_err    <= w_adx - w_ady;
      end else if (w_step && !w_last && !abort) begin
        r_err <= w_err_next;
        if (w_step_x) r_x <= r_sx_neg ? (r_x - 1'b1) : (r_x + 1'b1);
        if (w_step_y) r_y <= r_sy_neg ? (r_y - 1'b1) : (r_y + 1'b1);
      end
    end
  end

  assign cmd_ready = !w_full;
  assign px_valid  = (r_state == ST_DRAW) && w_on_screen;
  assign px_x      = r_x;
  assign px_y      = r_y;
  assign px_color  = r_color;
  assign busy      = (r_state != ST_IDLE) || !w_empty;
  assign line_done = r_line_done;

endmodule
